// File: rtl/ram_dual_rw_ctrl.sv
// ram_dual_rw_ctrl
//   Traffic generator/checker for a dual-port block RAM. Each pass writes the
//   whole exercised range through port A with the pattern (addr + pass_cnt),
//   then reads it back through port B and compares every returned word against
//   the same pattern. The sequence repeats forever.
// Ports
//   sys_clk            single clock for both RAM ports and this block
//   sys_rst            asynchronous reset, active low
//   ena/wea/addra/dina port A write side
//   enb/addrb          port B read request
//   doutb              port B read data, valid RD_LAT cycles after enb/addrb
//   pass_done          1-cycle pulse at the end of each pass
//   pass_cnt           completed passes (wraps)
//   err/err_cnt        sticky mismatch flag / saturating mismatch count
//   err_addr           address of the first mismatch
module ram_dual_rw_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int RD_LAT   = 1,
  parameter int ERRCNT_W = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  output logic                ena,
  output logic                wea,
  output logic [ADDR_W-1:0]   addra,
  output logic [DATA_W-1:0]   dina,
  output logic                enb,
  output logic [ADDR_W-1:0]   addrb,
  input  logic [DATA_W-1:0]   doutb,
  output logic                pass_done,
  output logic [15:0]         pass_cnt,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]   err_addr
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [15:0]       pc);
    return DATA_W'(a) + DATA_W'(pc);
  endfunction

  state_t                          state_q, state_d;
  logic                            ena_q, ena_d, wea_q, wea_d;
  logic [ADDR_W-1:0]               addra_q, addra_d;
  logic [DATA_W-1:0]               dina_q, dina_d;
  logic                            enb_q, enb_d;
  logic [ADDR_W-1:0]               addrb_q, addrb_d;
  logic                            pass_done_q, pass_done_d;
  logic [15:0]                     pass_cnt_q, pass_cnt_d;
  logic                            err_q, err_d;
  logic [ERRCNT_W-1:0]             err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]               err_addr_q, err_addr_d;

  // Compare pipeline: stage 0 captures the request presented on port B this
  // cycle, so the head (RD_LAT-1) lines up with doutb for that request.
  logic [RD_LAT-1:0]               vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0][DATA_W-1:0]   exp_pipe_q, exp_pipe_d;
  logic [RD_LAT-1:0][ADDR_W-1:0]   adr_pipe_q, adr_pipe_d;
  logic [RD_LAT-1:0]               vld_tail;
  logic                            drain_done;

  always_comb begin
    state_d     = state_q;
    ena_d       = ena_q;
    wea_d       = wea_q;
    addra_d     = addra_q;
    dina_d      = dina_q;
    enb_d       = enb_q;
    addrb_d     = addrb_q;
    pass_done_d = 1'b0;
    pass_cnt_d  = pass_cnt_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;

    vld_pipe_d    = vld_pipe_q;
    exp_pipe_d    = exp_pipe_q;
    adr_pipe_d    = adr_pipe_q;
    vld_pipe_d[0] = enb_q;
    exp_pipe_d[0] = pattern(addrb_q, pass_cnt_q);
    adr_pipe_d[0] = addrb_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      exp_pipe_d[i] = exp_pipe_q[i-1];
      adr_pipe_d[i] = adr_pipe_q[i-1];
    end

    if (vld_pipe_q[RD_LAT-1] && (doutb != exp_pipe_q[RD_LAT-1])) begin
      err_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
      if (!err_q) err_addr_d = adr_pipe_q[RD_LAT-1];
    end

    // The pass may end once only the head stage holds a request: that
    // compare happens this cycle and nothing else is in flight.
    vld_tail           = vld_pipe_q;
    vld_tail[RD_LAT-1] = 1'b0;
    drain_done         = ~|vld_tail;

    case (state_q)
      S_IDLE: begin
        state_d = S_WRITE;
        ena_d   = 1'b1;
        wea_d   = 1'b1;
        addra_d = '0;
        dina_d  = pattern('0, pass_cnt_q);
      end
      S_WRITE: begin
        if (addra_q == LAST_ADDR) begin
          // Read starts the very next cycle: no idle gap between the phases.
          state_d = S_READ;
          ena_d   = 1'b0;
          wea_d   = 1'b0;
          addra_d = '0;
          dina_d  = '0;
          enb_d   = 1'b1;
          addrb_d = '0;
        end else begin
          addra_d = addra_q + ADDR_W'(1);
          dina_d  = pattern(addra_q + ADDR_W'(1), pass_cnt_q);
        end
      end
      S_READ: begin
        if (addrb_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          enb_d   = 1'b0;
          addrb_d = '0;
        end else begin
          addrb_d = addrb_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d     = S_WRITE;
          pass_done_d = 1'b1;
          pass_cnt_d  = pass_cnt_q + 16'd1;
          ena_d       = 1'b1;
          wea_d       = 1'b1;
          addra_d     = '0;
          dina_d      = pattern('0, pass_cnt_q + 16'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= S_IDLE;
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      enb_q       <= 1'b0;
      addrb_q     <= '0;
      pass_done_q <= 1'b0;
      pass_cnt_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      vld_pipe_q  <= '0;
      exp_pipe_q  <= '0;
      adr_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      ena_q       <= ena_d;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      enb_q       <= enb_d;
      addrb_q     <= addrb_d;
      pass_done_q <= pass_done_d;
      pass_cnt_q  <= pass_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
      vld_pipe_q  <= vld_pipe_d;
      exp_pipe_q  <= exp_pipe_d;
      adr_pipe_q  <= adr_pipe_d;
    end
  end

  assign ena       = ena_q;
  assign wea       = wea_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign enb       = enb_q;
  assign addrb     = addrb_q;
  assign pass_done = pass_done_q;
  assign pass_cnt  = pass_cnt_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign err_addr  = err_addr_q;

endmodule
